debouncer: RTL and testbench

//  Per-bit button/switch debouncer placed directly after the 2-FF input synchronizer.

---
 rtl/debouncer_pkg.sv | 13 +
 rtl/debouncer_if.sv | 23 ++
 rtl/debouncer_sample_gen.sv | 30 +++
 rtl/debouncer.sv | 61 ++++++
 tb/tb_debouncer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/debouncer_pkg.sv
// Shared defaults and width helper for the debouncer slice.
// Counter widths are derived from the maximum value each counter must hold.
package debouncer_pkg;

    localparam int unsigned def_width            = 1;
    localparam int unsigned def_sample_count_max = 25000;
    localparam int unsigned def_pulse_count_max  = 150;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debouncer_if.sv
// Bundle between the synchronizer side and the debounced consumers.
// The debouncer sits on the slave side.
interface debouncer_if #(
    parameter int unsigned width = 1
);

    logic [width-1:0] glitchy_signal;
    logic [width-1:0] debounced_signal;
    logic [width-1:0] debounced_rise;

    modport master (
        output glitchy_signal,
        input  debounced_signal,
        input  debounced_rise
    );

    modport slave (
        input  glitchy_signal,
        output debounced_signal,
        output debounced_rise
    );

endinterface

// File: rtl/debouncer_sample_gen.sv
// Free-running sample timebase: one-cycle pulse every sample_count_max clocks.
// First pulse lands in cycle sample_count_max-1 after reset release.
module debouncer_sample_gen
    import debouncer_pkg::*;
#(
    parameter int unsigned sample_count_max = def_sample_count_max
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample_pulse
);

    localparam int unsigned cw = cnt_width(sample_count_max);
    localparam logic [cw-1:0] last = cw'(sample_count_max - 1);

    logic [cw-1:0] sample_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (sample_cnt == last) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + cw'(1);
        end
    end

    assign sample_pulse = (sample_cnt == last);

endmodule

// File: rtl/debouncer.sv
// Per-bit debouncer: saturating count of consecutive high samples per bit,
// level when saturated, registered one-cycle pulse on each debounced rise.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int unsigned width            = def_width,
    parameter int unsigned sample_count_max = def_sample_count_max,
    parameter int unsigned pulse_count_max  = def_pulse_count_max
) (
    input  logic       clk,
    input  logic       rst_n,
    debouncer_if.slave db
);

    localparam int unsigned sw = cnt_width(pulse_count_max + 1);
    localparam logic [sw-1:0] sat_max = sw'(pulse_count_max);

    logic             sample_pulse;
    logic [width-1:0] level;
    logic [width-1:0] prev_level;
    logic [width-1:0] rise_q;

    debouncer_sample_gen #(
        .sample_count_max(sample_count_max)
    ) u_sample_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_pulse(sample_pulse)
    );

    for (genvar i = 0; i < int'(width); i++) begin : g_bit
        logic [sw-1:0] sat_cnt;

        // A low input clears at once, even on a sample cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sat_cnt <= '0;
            end else if (!db.glitchy_signal[i]) begin
                sat_cnt <= '0;
            end else if (sample_pulse && sat_cnt < sat_max) begin
                sat_cnt <= sat_cnt + sw'(1);
            end
        end

        assign level[i] = (sat_cnt == sat_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_level <= '0;
            rise_q     <= '0;
        end else begin
            prev_level <= level;
            rise_q     <= level & ~prev_level;
        end
    end

    assign db.debounced_signal = level;
    assign db.debounced_rise   = rise_q;

endmodule

// File: tb/tb_debouncer.sv
// Randomized bench for debouncer against an arithmetic reference model.
// Model counts sample pulses since each bit was last seen low.
module tb_debouncer;

    localparam int W = 2;
    localparam int S = 4;
    localparam int P = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycle index since release, last low cycle per bit,
    // expected level one and two cycles back.
    int t;
    int last_low [W];
    bit sig_m1   [W];
    bit sig_m2   [W];

    debouncer_if #(.width(W)) db ();

    debouncer #(
        .width           (W),
        .sample_count_max(S),
        .pulse_count_max (P)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .db   (db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Pulses fall on cycles c with c % S == S-1; count those in [a, b].
    function automatic bit exp_level(input int i);
        int a;
        int b;
        int n;
        a = last_low[i] + 1;
        b = t - 1;
        if (b < a) return 1'b0;
        n = (b + 1) / S - a / S;
        return n >= P;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < W; i++) begin
            last_low[i] = -1;
            sig_m1[i]   = 1'b0;
            sig_m2[i]   = 1'b0;
        end
    endtask

    task automatic step(input logic [W-1:0] g);
        logic [W-1:0] es;
        logic [W-1:0] er;
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            es[i] = exp_level(i);
            er[i] = sig_m1[i] && !sig_m2[i];
        end
        check("level", 32'(db.debounced_signal), 32'(es));
        check("rise", 32'(db.debounced_rise), 32'(er));
        for (int i = 0; i < W; i++) begin
            sig_m2[i] = sig_m1[i];
            sig_m1[i] = es[i];
            if (!g[i]) last_low[i] = t;
        end
        db.glitchy_signal = g;
        t++;
    endtask

    // Mid-cycle async assert, hold n cycles, release just after a posedge.
    task automatic do_reset(input int n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_level", 32'(db.debounced_signal), 32'd0);
        check("async_rise", 32'(db.debounced_rise), 32'd0);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            db.glitchy_signal = 2'b11;
            check("rst_level", 32'(db.debounced_signal), 32'd0);
            check("rst_rise", 32'(db.debounced_rise), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int mode;
        int len;
        logic [W-1:0] g;

        db.glitchy_signal = 2'b11;
        model_reset();

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rst_level", 32'(db.debounced_signal), 32'd0);
            check("rst_rise", 32'(db.debounced_rise), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // clean press on bit 0
        for (int c = 0; c < 20; c++) step(2'b01);

        // one-cycle bounce at cycle 10
        do_reset(2);
        for (int c = 0; c < 28; c++) step(c == 10 ? 2'b00 : 2'b01);

        // saturation, release of bit 1, re-press
        for (int c = 0; c < 200; c++) step(2'b11);
        step(2'b01);
        for (int c = 0; c < 20; c++) step(2'b11);

        // reset after two sample pulses of progress
        do_reset(1);
        for (int c = 0; c < 9; c++) step(2'b11);
        do_reset(1);
        for (int c = 0; c < 20; c++) step(2'b11);

        for (int p = 0; p < 40; p++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(8, 40);
            if (p % 10 == 9) do_reset($urandom_range(1, 3));
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0: g = '1;
                    1: for (int i = 0; i < W; i++)
                           g[i] = ($urandom_range(0, 7) != 0);
                    2: g = W'($urandom);
                    default: g = '0;
                endcase
                step(g);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
